// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scan receiver
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_e;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } fifo_entry_t;

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// rtl/ps2_scan_receiver_if.sv - decoded scan-code valid/ready handshake
interface ps2_scan_receiver_if;

   logic       code_valid;
   logic       code_ready;
   logic [7:0] code_byte;
   logic       code_extended;
   logic       code_release;

   modport master (
      output code_valid,
      output code_byte,
      output code_extended,
      output code_release,
      input  code_ready
   );

   modport slave (
      input  code_valid,
      input  code_byte,
      input  code_extended,
      input  code_release,
      output code_ready
   );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Accept pops only when data exists; a full FIFO still takes a push if it pops in the same cycle.
   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care while empty so it is not reset.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 keyboard frame receiver with prefix folding and code FIFO
module ps2_scan_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 250000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   ps2_scan_receiver_if.master           code_if,
   output logic                          frame_error,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int FCW = $clog2(FILTER_LEN);
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

   logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
   logic clk_meta_d, clk_sync_d, dat_meta_d, dat_sync_d;

   logic           filt_q, filt_d;
   logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
   logic           fall;

   frame_state_e   state_q, state_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [7:0]     shift_q, shift_d;
   logic           par_ok_q, par_ok_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic           good_q, good_d;
   logic           err_q, err_d;

   logic           ext_pend_q, ext_pend_d;
   logic           rel_pend_q, rel_pend_d;
   logic           push_req;
   fifo_entry_t    push_entry;
   fifo_entry_t    head;
   logic           fifo_full, fifo_empty, pop;

   // Two-stage synchronisers for both raw PS/2 lines.
   always_comb begin
      clk_meta_d = ps2_clk;
      clk_sync_d = clk_meta_q;
      dat_meta_d = ps2_data;
      dat_sync_d = dat_meta_q;
   end

   // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_sync_q != filt_q) begin
         if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q;
         end else begin
            filt_cnt_d = filt_cnt_q + FCW'(1);
         end
      end
      fall = filt_q && !filt_d;
   end

   // Frame FSM and watchdog: next state, bit shifting, parity/stop checks and timeout abort.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_ok_d  = par_ok_q;
      wd_d      = '0;
      good_d    = 1'b0;
      err_d     = 1'b0;
      if (state_q != ST_IDLE && !fall) begin
         wd_d = wd_q + WDW'(1);
      end
      case (state_q)
         ST_IDLE: begin
            if (fall && !dat_sync_q) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (fall) begin
               shift_d   = {dat_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (fall) begin
               par_ok_d = ^{shift_q, dat_sync_q};
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               state_d = ST_IDLE;
               if (dat_sync_q && par_ok_q) begin
                  good_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_q != ST_IDLE && !fall && wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
         wd_d    = '0;
      end
   end

   // Prefix folding: E0/F0 only arm flags, any other good byte is pushed with the flags attached.
   always_comb begin
      ext_pend_d = ext_pend_q;
      rel_pend_d = rel_pend_q;
      push_req   = 1'b0;
      push_entry = '{ext: ext_pend_q, rel: rel_pend_q, code: shift_q};
      if (err_q) begin
         ext_pend_d = 1'b0;
         rel_pend_d = 1'b0;
      end else if (good_q) begin
         if (shift_q == PS2_PREFIX_EXT) begin
            ext_pend_d = 1'b1;
         end else if (shift_q == PS2_PREFIX_REL) begin
            rel_pend_d = 1'b1;
         end else begin
            push_req   = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
         end
      end
   end

   // All receiver state registers; idle lines read as high out of reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
         state_q    <= ST_IDLE;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         par_ok_q   <= 1'b0;
         wd_q       <= '0;
         good_q     <= 1'b0;
         err_q      <= 1'b0;
         ext_pend_q <= 1'b0;
         rel_pend_q <= 1'b0;
      end else begin
         clk_meta_q <= clk_meta_d;
         clk_sync_q <= clk_sync_d;
         dat_meta_q <= dat_meta_d;
         dat_sync_q <= dat_sync_d;
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         par_ok_q   <= par_ok_d;
         wd_q       <= wd_d;
         good_q     <= good_d;
         err_q      <= err_d;
         ext_pend_q <= ext_pend_d;
         rel_pend_q <= rel_pend_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_req),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign pop                   = !fifo_empty && code_if.code_ready;
   assign overflow              = push_req && fifo_full && !pop;
   assign frame_error           = err_q;
   assign code_if.code_valid    = !fifo_empty;
   assign code_if.code_byte     = fifo_empty ? 8'h00 : head.code;
   assign code_if.code_extended = !fifo_empty && head.ext;
   assign code_if.code_release  = !fifo_empty && head.rel;

endmodule
